retire_buffer: RTL

// In-order retirement buffer for the out-of-order completion path: allocates a 20-bit instruction_id at

---
 rtl/retire_buffer_pkg.sv | 17 +
 rtl/retire_entry_array.sv | 64 ++++++
 rtl/retire_buffer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/retire_buffer_pkg.sv
// Shared types for the retire path: register index and one retire-buffer entry.
package retire_buffer_pkg;

  localparam int RETIRE_ID_WIDTH = 20;

  typedef logic [4:0] MipsReg;

  typedef struct packed {
    logic                       valid;
    logic                       done;
    logic [RETIRE_ID_WIDTH-1:0] id;
    logic                       uses_rw;
    MipsReg                     rw_addr;
    logic [31:0]                rw_data;
  } RetireEntry;

endpackage

// File: rtl/retire_entry_array.sv
// DEPTH x RetireEntry store: alloc write, completion write, head clear, flush-all; head and completion lookups are combinational.
// Writes land on the rising edge. This module never stalls; all arbitration is done by the parent.
module retire_entry_array
  import retire_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int IDX  = $clog2(DEPTH)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_alloc_en,
  input  logic [IDX-1:0]             i_alloc_idx,
  input  logic [RETIRE_ID_WIDTH-1:0] i_alloc_id,
  input  logic                       i_cmpl_en,
  input  logic [IDX-1:0]             i_cmpl_idx,
  input  logic                       i_cmpl_uses_rw,
  input  MipsReg                     i_cmpl_rw_addr,
  input  logic [31:0]                i_cmpl_rw_data,
  input  logic                       i_clr_en,
  input  logic [IDX-1:0]             i_head_idx,
  output RetireEntry                 o_head_ent,
  output logic                       o_cmpl_open,
  output logic [RETIRE_ID_WIDTH-1:0] o_cmpl_ent_id
);

  RetireEntry r_ent [DEPTH];

  assign o_head_ent    = r_ent[i_head_idx];
  assign o_cmpl_open   = r_ent[i_cmpl_idx].valid && !r_ent[i_cmpl_idx].done;
  assign o_cmpl_ent_id = r_ent[i_cmpl_idx].id;

  // The three write ports never target the same live entry, so their order here is irrelevant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i].valid <= 1'b0;
        r_ent[i].done  <= 1'b0;
      end
    end else begin
      if (i_alloc_en) begin
        r_ent[i_alloc_idx].valid   <= 1'b1;
        r_ent[i_alloc_idx].done    <= 1'b0;
        r_ent[i_alloc_idx].id      <= i_alloc_id;
        r_ent[i_alloc_idx].uses_rw <= 1'b0;
        r_ent[i_alloc_idx].rw_addr <= '0;
        r_ent[i_alloc_idx].rw_data <= '0;
      end
      if (i_cmpl_en) begin
        r_ent[i_cmpl_idx].done    <= 1'b1;
        r_ent[i_cmpl_idx].uses_rw <= i_cmpl_uses_rw;
        r_ent[i_cmpl_idx].rw_addr <= i_cmpl_rw_addr;
        r_ent[i_cmpl_idx].rw_data <= i_cmpl_rw_data;
      end
      if (i_clr_en) begin
        r_ent[i_head_idx].valid <= 1'b0;
        r_ent[i_head_idx].done  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/retire_buffer.sv
// In-order retire buffer: grants ids at decode, accepts completions in any order, retires in order to write-back.
// Write-back two cycles after the head completes (one with RETIRE_BYPASS_EN); alloc stalls when full or flushing.
module retire_buffer
  import retire_buffer_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int ID_WIDTH = RETIRE_ID_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  output logic [ID_WIDTH-1:0]      alloc_id,
  input  logic                     cmpl_valid,
  input  logic [ID_WIDTH-1:0]      cmpl_id,
  input  logic                     cmpl_uses_rw,
  input  logic [4:0]               cmpl_rw_addr,
  input  logic [31:0]              cmpl_rw_data,
  output logic                     cmpl_err,
  output logic                     retire_valid,
  output logic [ID_WIDTH-1:0]      retire_id,
  output logic                     wb_uses_rw,
  output logic [4:0]               wb_rw_addr,
  output logic [31:0]              wb_rw_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX = $clog2(DEPTH);
  localparam logic [IDX:0] CNT_FULL = (IDX+1)'(DEPTH);

  logic [IDX-1:0]             r_head, r_tail;
  logic [IDX:0]               r_count;
  logic [ID_WIDTH-1:0]        r_next_id;
  logic                       r_retire_valid, r_wb_uses_rw, r_cmpl_err;
  logic [ID_WIDTH-1:0]        r_retire_id;
  MipsReg                     r_wb_rw_addr;
  logic [31:0]                r_wb_rw_data;

  RetireEntry                 w_head_ent;
  logic                       w_cmpl_open;
  logic [RETIRE_ID_WIDTH-1:0] w_cmpl_ent_id;
  logic [IDX-1:0]             w_cmpl_idx;
  logic                       w_alloc_fire, w_cmpl_hit, w_head_done, w_bypass;
  logic                       w_retire, w_cmpl_wr;
  logic                       w_ret_uses_rw;
  MipsReg                     w_ret_addr;
  logic [31:0]                w_ret_data;

  assign w_cmpl_idx   = cmpl_id[IDX-1:0];
  assign alloc_ready  = (r_count < CNT_FULL) && !flush;
  assign alloc_id     = r_next_id;
  assign w_alloc_fire = alloc_valid && alloc_ready;

  assign w_cmpl_hit  = cmpl_valid && w_cmpl_open && (w_cmpl_ent_id == RETIRE_ID_WIDTH'(cmpl_id));
  assign w_head_done = w_head_ent.valid && w_head_ent.done;

`ifdef RETIRE_BYPASS_EN
  // Live entries are contiguous from head, so an open hit at the head index is the head itself.
  assign w_bypass = w_cmpl_hit && (w_cmpl_idx == r_head);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_retire      = w_head_done || w_bypass;
  assign w_cmpl_wr     = w_cmpl_hit && !w_bypass && !flush;
  assign w_ret_uses_rw = w_bypass ? cmpl_uses_rw : w_head_ent.uses_rw;
  assign w_ret_addr    = w_bypass ? cmpl_rw_addr : w_head_ent.rw_addr;
  assign w_ret_data    = w_bypass ? cmpl_rw_data : w_head_ent.rw_data;

  retire_entry_array #(.DEPTH(DEPTH)) u_entries (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flush        (flush),
    .i_alloc_en     (w_alloc_fire),
    .i_alloc_idx    (r_tail),
    .i_alloc_id     (RETIRE_ID_WIDTH'(r_next_id)),
    .i_cmpl_en      (w_cmpl_wr),
    .i_cmpl_idx     (w_cmpl_idx),
    .i_cmpl_uses_rw (cmpl_uses_rw),
    .i_cmpl_rw_addr (cmpl_rw_addr),
    .i_cmpl_rw_data (cmpl_rw_data),
    .i_clr_en       (w_retire),
    .i_head_idx     (r_head),
    .o_head_ent     (w_head_ent),
    .o_cmpl_open    (w_cmpl_open),
    .o_cmpl_ent_id  (w_cmpl_ent_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_next_id      <= '0;
      r_retire_valid <= 1'b0;
      r_retire_id    <= '0;
      r_wb_uses_rw   <= 1'b0;
      r_wb_rw_addr   <= '0;
      r_wb_rw_data   <= '0;
      r_cmpl_err     <= 1'b0;
    end else begin
      // Outputs are single-cycle pulses; zero unless reloaded below.
      r_retire_valid <= 1'b0;
      r_retire_id    <= '0;
      r_wb_uses_rw   <= 1'b0;
      r_wb_rw_addr   <= '0;
      r_wb_rw_data   <= '0;
      r_cmpl_err     <= 1'b0;
      if (flush) begin
        r_head  <= r_tail;
        r_count <= '0;
      end else begin
        if (w_alloc_fire) begin
          r_tail    <= r_tail + 1'b1;
          r_next_id <= r_next_id + 1'b1;
        end
        if (w_retire) begin
          r_head         <= r_head + 1'b1;
          r_retire_valid <= 1'b1;
          r_retire_id    <= ID_WIDTH'(w_head_ent.id);
          r_wb_uses_rw   <= w_ret_uses_rw;
          r_wb_rw_addr   <= w_ret_addr;
          r_wb_rw_data   <= w_ret_data;
        end
        r_cmpl_err <= cmpl_valid && !w_cmpl_hit;
        case ({w_alloc_fire, w_retire})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign retire_valid = r_retire_valid;
  assign retire_id    = r_retire_id;
  assign wb_uses_rw   = r_wb_uses_rw;
  assign wb_rw_addr   = r_wb_rw_addr;
  assign wb_rw_data   = r_wb_rw_data;
  assign cmpl_err     = r_cmpl_err;
  assign count        = r_count;

endmodule
